// File: rtl/one_flow_shell_if.sv
// one_flow_shell_if: operand stream, adder hookup and result stream of one_flow_shell.
interface one_flow_shell_if #(
  parameter int WIDTH = 32
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_x, in_y, add_x, add_y, add_out, out_data;
  modport slave (
    input in_valid, in_x, in_y, add_out, out_ready,
    output in_ready, add_x, add_y, out_valid, out_data
  );
  modport master (
    output in_valid, in_x, in_y, add_out, out_ready,
    input in_ready, add_x, add_y, out_valid, out_data
  );
endinterface

// File: rtl/one_flow_shell.sv
// one_flow_shell: credit-gated valid/ready shell around a fixed-latency adder.
// Defining ONE_FLOW_SHELL_STATS_EN adds the stat_stall_cycles counter port.
module one_flow_shell #(
  parameter int WIDTH = 32,
  parameter int LATENCY = 2,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  one_flow_shell_if.slave bus
`ifdef ONE_FLOW_SHELL_STATS_EN
  ,
  output logic [31:0] stat_stall_cycles
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic accept, pop, wr;
  logic [CW-1:0] credits_q, credits_d, count_q, count_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_comb begin
    bus.add_x = bus.in_x;
    bus.add_y = bus.in_y;
    bus.in_ready = credits_q != '0;
    bus.out_valid = count_q != '0;
    bus.out_data = mem_q[rd_ptr_q];
    accept = bus.in_valid && bus.in_ready;
    pop = bus.out_valid && bus.out_ready;
    wr = vld_q[LATENCY-1];
    // a credit is held from acceptance until its result leaves the FIFO
    credits_d = credits_q - CW'(accept) + CW'(pop);
    count_d = count_q + CW'(wr) - CW'(pop);
    vld_d = LATENCY'({vld_q, accept});
    wr_ptr_d = !wr ? wr_ptr_q : wr_ptr_q == PW'(DEPTH - 1) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d = !pop ? rd_ptr_q : rd_ptr_q == PW'(DEPTH - 1) ? '0 : rd_ptr_q + PW'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits_q <= CW'(DEPTH);
      count_q <= '0;
      vld_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      credits_q <= credits_d;
      count_q <= count_d;
      vld_q <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // storage is left unreset; count gates visibility of stale entries
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= bus.add_out;
  end
`ifdef ONE_FLOW_SHELL_STATS_EN
  logic [31:0] stall_q, stall_d;
  always_comb stall_d = (bus.in_valid && !bus.in_ready && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk) stall_q <= !rst_n ? '0 : stall_d;
  assign stat_stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_one_flow_shell.sv
// tb_one_flow_shell: scoreboard bench for one_flow_shell with a behavioural 2-cycle adder.
module tb_one_flow_shell;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] s1;
  one_flow_shell_if #(.WIDTH(32)) bus ();
`ifdef ONE_FLOW_SHELL_STATS_EN
  logic [31:0] stat;
`endif
  one_flow_shell dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef ONE_FLOW_SHELL_STATS_EN
    ,
    .stat_stall_cycles(stat)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    s1 <= bus.add_x + bus.add_y;
    bus.add_out <= s1;
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] x, input logic [31:0] y);
    bus.in_valid = 1;
    bus.in_x = x;
    bus.in_y = y;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        tick();
        return;
      end
      tick();
    end
    fail("send");
  endtask
  task automatic drain;
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
    check("drain_empty", exp_q.size(), 0);
    check("drain_no_vld", bus.out_valid, 0);
  endtask
  // model: every accepted pair must come back as (x+y) mod 2^32, in order
  always @(negedge clk) begin
    if (!rst_n) exp_q.delete();
    else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out actual=%0h expected=none", bus.out_data);
        end else check("sb_data", bus.out_data, exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_x + bus.in_y);
    end
  end
  initial begin
    int acc, first, last, nov;
    bus.in_valid = 0;
    bus.in_x = 0;
    bus.in_y = 0;
    bus.out_ready = 0;
    tick();
    tick();
    rst_n = 1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    tick();
    bus.out_ready = 1;
    bus.in_valid = 1;
    bus.in_x = 5;
    bus.in_y = 7;
    @(negedge clk);
    check("single_accept", bus.in_ready, 1);
    tick();
    bus.in_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("single_vld", bus.out_valid, k == 3);
      if (k == 3) check("single_data", bus.out_data, 12);
      tick();
    end
    send(32'hFFFFFFFF, 32'h1);
    send(32'h80000000, 32'h80000000);
    bus.in_valid = 0;
    drain();
    bus.out_ready = 0;
    acc = 0;
    bus.in_valid = 1;
    bus.in_x = 1;
    bus.in_y = 1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc++;
        tick();
        bus.in_x = acc + 1;
        bus.in_y = acc + 1;
      end else tick();
    end
    check("bp_accepts", acc, 4);
    @(negedge clk);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    tick();
    bus.out_ready = 1;
    @(negedge clk);
    check("bp_first_pop_in_ready", bus.in_ready, 0);
    check("bp_first_data", bus.out_data, 2);
    tick();
    @(negedge clk);
    check("bp_in_ready_after_pop", bus.in_ready, 1);
    tick();
    send(6, 6);
    bus.in_valid = 0;
    drain();
    first = -1;
    last = -1;
    nov = 0;
    for (int t = 0; t < 110; t++) begin
      if (t < 100) begin
        bus.in_valid = 1;
        bus.in_x = $urandom;
        bus.in_y = $urandom;
      end else bus.in_valid = 0;
      @(negedge clk);
      if (t < 100) check("tp_in_ready", bus.in_ready, 1);
      if (bus.out_valid) begin
        if (first < 0) first = t;
        last = t;
        nov++;
      end
      tick();
    end
    check("tp_first_out", first, 3);
    check("tp_count", nov, 100);
    check("tp_contiguous", last - first + 1, 100);
    drain();
    send(32'h11, 32'h22);
    send(32'h33, 32'h44);
    bus.in_valid = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_in_ready", bus.in_ready, 1);
      tick();
    end
`ifdef ONE_FLOW_SHELL_STATS_EN
    check("stat_reset", stat, 0);
    bus.out_ready = 0;
    for (int i = 0; i < 4; i++) send(i, 100);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("stat_stalled", bus.in_ready, 0);
      tick();
    end
    bus.in_valid = 0;
    @(negedge clk);
    check("stat_count", stat, 3);
    tick();
    bus.out_ready = 1;
`endif
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
